// File: rtl/conware_pkg.sv
// Shared definitions for the Game-of-Life stream blocks.
// Contents: default live/dead colour words, the frame-source FSM state
// enum, and the address-width helper used by the stream/buffer blocks.
package conware_pkg;

    localparam logic [31:0] ALIVE_COLOR_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] DEAD_COLOR_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DONE
    } state_t;

    // Width needed to index n entries, never narrower than one bit.
    function automatic int clog2_min2(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/board2axis_if.sv
// AXI4-Stream bundle carrying colour words out of board2axis.
// Signals: tvalid, tready, tdata[DWIDTH], tlast, tkeep/tstrb[DWIDTH/8].
// master: drives everything except tready; slave: drives tready.
interface board2axis_if #(
    parameter int DWIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DWIDTH-1:0]     tdata;
    logic                  tlast;
    logic [DWIDTH/8-1:0]   tkeep;
    logic [DWIDTH/8-1:0]   tstrb;

    modport master (
        output tvalid, tdata, tlast, tkeep, tstrb,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tlast, tkeep, tstrb,
        output tready
    );
endinterface

// File: rtl/board_row_mem.sv
// Row-organised board store: one write port, one synchronous read port.
// Ports: clk; wr_en/wr_addr/wr_data write a full row; wr_oob flags a write
// address outside 0..HEIGHT-1 (such writes never touch the array);
// rd_en/rd_addr latch a row into rd_data on the next edge.
// The array is not reset: a stored board survives a controller reset.
module board_row_mem #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 1,
    parameter int AW     = 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_oob,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    // Sized to the full address space so every address value indexes a
    // real entry; rows at or above HEIGHT are never written.
    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] store [DEPTH];

    assign wr_oob = 32'(wr_addr) >= 32'(HEIGHT);

    always_ff @(posedge clk) begin
        if (wr_en && !wr_oob) begin
            store[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= store[rd_addr];
        end
    end
endmodule

// File: rtl/board2axis.sv
// Frame source: holds a WIDTH x HEIGHT board of cell bits and, on start,
// streams it row-major as AXI4-Stream colour words with TLAST on the last
// pixel of the frame.
// Ports: ACLK/ARESET (sync, active-high); row_wr_* row write port (IDLE
// only); start; busy/done/wr_drop status; m_axis stream master;
// num_writes (accepted beats) and frames_sent (completed frames).
module board2axis
    import conware_pkg::*;
#(
    parameter int                DWIDTH      = 32,
    parameter int                WIDTH       = 8,
    parameter int                HEIGHT      = 1,
    parameter logic [DWIDTH-1:0] ALIVE_COLOR = ALIVE_COLOR_DEF,
    parameter logic [DWIDTH-1:0] DEAD_COLOR  = DEAD_COLOR_DEF,
    localparam int               ROW_AW      = clog2_min2(HEIGHT)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              row_wr_en,
    input  logic [ROW_AW-1:0] row_wr_addr,
    input  logic [WIDTH-1:0]  row_wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              wr_drop,
    board2axis_if.master      m_axis,
    output logic [31:0]       num_writes,
    output logic [31:0]       frames_sent
);
    localparam int                COL_AW   = clog2_min2(WIDTH);
    localparam logic [COL_AW-1:0] COL_LAST = COL_AW'(WIDTH - 1);
    localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(HEIGHT - 1);

    state_t               state, state_nxt;
    logic [ROW_AW-1:0]    row, row_nxt;
    logic [COL_AW-1:0]    col, col_nxt;
    logic [WIDTH-1:0]     row_reg;
    logic [2**COL_AW-1:0] row_pad;
    logic                 mem_wr_en;
    logic                 mem_rd_en;
    logic                 wr_oob;
    logic                 beat_hs;
    logic                 tvalid_c;
    logic                 tlast_c;
    logic [DWIDTH-1:0]    tdata_c;

    // Writes only land while idle, so a streaming frame never sees its
    // rows change underneath it.
    assign mem_wr_en = row_wr_en && (state == ST_IDLE);

    // The memory read register doubles as the row register: it is loaded
    // during LOAD (read address = row) and holds through STREAM.
    board_row_mem #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .AW     (ROW_AW)
    ) u_mem (
        .clk     (ACLK),
        .wr_en   (mem_wr_en),
        .wr_addr (row_wr_addr),
        .wr_data (row_wr_data),
        .wr_oob  (wr_oob),
        .rd_en   (mem_rd_en),
        .rd_addr (row),
        .rd_data (row_reg)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= ST_IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
        end
    end

    always_comb begin
        row_pad                = '0;
        row_pad[WIDTH-1:0]     = row_reg;
        state_nxt              = state;
        row_nxt                = row;
        col_nxt                = col;
        mem_rd_en              = 1'b0;
        beat_hs                = 1'b0;
        tvalid_c               = 1'b0;
        tlast_c                = 1'b0;
        tdata_c                = DEAD_COLOR;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end
            end
            ST_LOAD: begin
                mem_rd_en = 1'b1;
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                tvalid_c = 1'b1;
                tdata_c  = row_pad[col] ? ALIVE_COLOR : DEAD_COLOR;
                tlast_c  = (row == ROW_LAST) && (col == COL_LAST);
                // Without TREADY nothing advances, which keeps TDATA/TLAST
                // stable for the stalled beat.
                if (m_axis.tready) begin
                    beat_hs = 1'b1;
                    if (col != COL_LAST) begin
                        col_nxt = col + 1'b1;
                    end else if (row != ROW_LAST) begin
                        col_nxt   = '0;
                        row_nxt   = row + 1'b1;
                        state_nxt = ST_LOAD;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_drop     <= 1'b0;
            num_writes  <= '0;
            frames_sent <= '0;
        end else begin
            busy    <= (state_nxt != ST_IDLE);
            done    <= (state_nxt == ST_DONE);
            wr_drop <= row_wr_en && ((state != ST_IDLE) || wr_oob);
            if (beat_hs) begin
                num_writes <= num_writes + 32'd1;
            end
            if (state == ST_DONE) begin
                frames_sent <= frames_sent + 32'd1;
            end
        end
    end

    assign m_axis.tvalid = tvalid_c;
    assign m_axis.tdata  = tdata_c;
    assign m_axis.tlast  = tlast_c;
    assign m_axis.tkeep  = {(DWIDTH/8){1'b1}};
    assign m_axis.tstrb  = {(DWIDTH/8){1'b1}};

endmodule
